// File: rtl/vga_timing_pkg.sv
// Shared 1440x900 scan timing constants, scan-control payload and window helper.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned COL_W = 4;

    localparam int unsigned VGA_H_ACTIVE = 1440;
    localparam int unsigned VGA_H_FP     = 80;
    localparam int unsigned VGA_H_SYNC   = 152;
    localparam int unsigned VGA_H_BP     = 232;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int unsigned VGA_V_ACTIVE = 900;
    localparam int unsigned VGA_V_FP     = 3;
    localparam int unsigned VGA_V_SYNC   = 6;
    localparam int unsigned VGA_V_BP     = 25;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic VGA_HS_POL = 1'b0;
    localparam logic VGA_VS_POL = 1'b1;

    localparam int unsigned VGA_DRAW_LAT = 1;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } scan_ctl_t;

    localparam int unsigned SCAN_CTL_W = $bits(scan_ctl_t);

    // Half-open window test lo <= pos < hi in counter-width arithmetic.
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of DEPTH stages; every stage resets to IDLE.
module sync_delay_line #(
    parameter int unsigned     WIDTH = 3,
    parameter int unsigned     DEPTH = 1,
    parameter logic [WIDTH-1:0] IDLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        assign data_o = data_i;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= IDLE;
            end else if (en_i) begin
                stage_q[0] <= data_i;
                for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign data_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator: position counters, sync/active pipeline matched to
// the renderer latency, and registered colour/sync outputs.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        HS_POL   = VGA_HS_POL,
    parameter logic        VS_POL   = VGA_VS_POL,
    parameter int unsigned DRAW_LAT = VGA_DRAW_LAT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [3:0]  draw_r,
    input  logic [3:0]  draw_g,
    input  logic [3:0]  draw_b,
    output logic [10:0] curr_x,
    output logic [10:0] curr_y,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam scan_ctl_t IDLE_CTL = '{active: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL};

    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic               hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [3*COL_W-1:0] rgb_q, rgb_d;
    scan_ctl_t          raw_c, dly_c;

    // Undelayed control for the position currently on the counters.
    always_comb begin
        raw_c.active = (x_q < H_ACT) && (y_q < V_ACT);
        raw_c.hsync  = in_window(x_q, HS_START, HS_END) ? HS_POL : ~HS_POL;
        raw_c.vsync  = in_window(y_q, VS_START, VS_END) ? VS_POL : ~VS_POL;
    end

    // First DRAW_LAT stages; the output register below supplies the last one.
    sync_delay_line #(
        .WIDTH (SCAN_CTL_W),
        .DEPTH (DRAW_LAT),
        .IDLE  (IDLE_CTL)
    ) u_sync_delay (
        .clk    (clk),
        .rst_n  (rst),
        .en_i   (pix_en),
        .data_i (raw_c),
        .data_o (dly_c)
    );

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        fs_d  = 1'b0;
        if (pix_en) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + CNT_W'(1);
                end
            end else begin
                x_d = x_q + CNT_W'(1);
            end
            // Renderer colour for the delayed position arrives now; blank outside active.
            hs_d  = dly_c.hsync;
            vs_d  = dly_c.vsync;
            rgb_d = dly_c.active ? {draw_r, draw_g, draw_b} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            rgb_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
            fs_q  <= fs_d;
        end
    end

    assign curr_x      = x_q;
    assign curr_y      = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign vga_r       = rgb_q[3*COL_W-1:2*COL_W];
    assign vga_g       = rgb_q[2*COL_W-1:COL_W];
    assign vga_b       = rgb_q[COL_W-1:0];
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench: three scan generators (full 1440x900, two shrunken timings
// with other latencies/polarities) checked every clock against a raster model.
module tb_vga_scan_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        fs;
    } exp_t;

    typedef struct {
        int unsigned ha, hfp, hsw, hbp, va, vfp, vsw, vbp, lat;
        logic        hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    logic [3:0] draw_r = '0, draw_g = '0, draw_b = '0;

    logic [10:0] cx [3];
    logic [10:0] cy [3];
    logic        hs_o [3];
    logic        vs_o [3];
    logic [3:0]  r_o [3];
    logic [3:0]  g_o [3];
    logic [3:0]  b_o [3];
    logic        fs_o [3];
    exp_t        act [3];

    always #5 clk = ~clk;

    vga_scan_gen u_dflt (
        .clk(clk), .rst(rst_n), .pix_en(pix_en),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .curr_x(cx[0]), .curr_y(cy[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
        .vga_r(r_o[0]), .vga_g(g_o[0]), .vga_b(b_o[0]), .frame_start(fs_o[0])
    );

    vga_scan_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b0), .DRAW_LAT(2)
    ) u_small (
        .clk(clk), .rst(rst_n), .pix_en(pix_en),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .curr_x(cx[1]), .curr_y(cy[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
        .vga_r(r_o[1]), .vga_g(g_o[1]), .vga_b(b_o[1]), .frame_start(fs_o[1])
    );

    vga_scan_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .DRAW_LAT(0)
    ) u_zero (
        .clk(clk), .rst(rst_n), .pix_en(pix_en),
        .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
        .curr_x(cx[2]), .curr_y(cy[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
        .vga_r(r_o[2]), .vga_g(g_o[2]), .vga_b(b_o[2]), .frame_start(fs_o[2])
    );

    for (genvar k = 0; k < 3; k++) begin : g_act
        assign act[k] = {cx[k], cy[k], hs_o[k], vs_o[k], r_o[k], g_o[k], b_o[k], fs_o[k]};
    end

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned n_pos = 0;
    logic [11:0] hist [$];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    int unsigned fs_want = 0;
    int unsigned fs_seen = 0;
    bit sb_go = 1'b0;
    bit sb_stop = 1'b0;

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{1440, 80, 152, 232, 900, 3, 6, 25, 1, 1'b0, 1'b1};
            1:       c = '{20, 3, 4, 5, 6, 2, 3, 2, 2, 1'b1, 1'b0};
            default: c = '{16, 2, 3, 3, 5, 1, 2, 1, 0, 1'b0, 1'b1};
        endcase
        return c;
    endfunction

    // Expected outputs once n positions have been scanned since reset.
    function automatic exp_t model(input int i, input int unsigned n, input logic adv);
        cfg_t c;
        exp_t e;
        int unsigned ht, vt, m, px, py;
        c  = get_cfg(i);
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        e.x   = 11'(n % ht);
        e.y   = 11'((n / ht) % vt);
        e.hs  = ~c.hp;
        e.vs  = ~c.vp;
        e.rgb = '0;
        if (n > c.lat) begin
            m  = n - c.lat - 1;
            px = m % ht;
            py = (m / ht) % vt;
            if (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hsw) e.hs = c.hp;
            if (py >= c.va + c.vfp && py < c.va + c.vfp + c.vsw) e.vs = c.vp;
            if (px < c.ha && py < c.va) e.rgb = hist[n-1];
        end
        e.fs = adv && (n % (ht * vt) == 0);
        return e;
    endfunction

    task automatic check(input string nm, input int i, input exp_t a, input exp_t e);
        n_chk++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d t=%0t got x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b want x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b",
                     nm, i, $time, a.x, a.y, a.hs, a.vs, a.rgb, a.fs, e.x, e.y, e.hs, e.vs, e.rgb, e.fs);
        end
    endtask

    task automatic push_all(input logic adv);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = model(i, n_pos, adv);
            case (i)
                0:       q0.push_back(e);
                1:       begin q1.push_back(e); if (e.fs) fs_want++; end
                default: q2.push_back(e);
            endcase
        end
        sb_go = 1'b1;
    endtask

    // One clock of stimulus; the expectation for the following rising edge is queued.
    task automatic step(input logic rst_v, input logic en, input logic [11:0] d);
        logic fell;
        @(negedge clk);
        fell   = rst_n && !rst_v;
        rst_n  = rst_v;
        pix_en = en;
        {draw_r, draw_g, draw_b} = d;
        if (!rst_v) begin
            n_pos = 0;
            hist.delete();
        end else if (en) begin
            hist.push_back(d);
            n_pos++;
        end
        push_all(rst_v && en);
        if (fell) begin
            #1;
            for (int i = 0; i < 3; i++) check("rst_async", i, act[i], model(i, 0, 1'b0));
        end
    endtask

    // Monitor: every clock each DUT presents a full output vector to compare.
    initial begin
        exp_t e;
        wait (sb_go);
        while (!sb_stop) begin
            @(posedge clk);
            #1;
            if (sb_stop) break;
            if (fs_o[1]) fs_seen++;
            for (int i = 0; i < 3; i++) begin
                if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0) ||
                    (i == 2 && q2.size() == 0)) begin
                    n_chk++;
                    $display("FAIL underrun dut%0d t=%0t got empty queue want entry", i, $time);
                end else begin
                    case (i)
                        0:       e = q0.pop_front();
                        1:       e = q1.pop_front();
                        default: e = q2.pop_front();
                    endcase
                    check("scan", i, act[i], e);
                end
            end
        end
    end

    initial begin
        repeat (3) step(1'b0, 1'b0, 12'h000);
        // Continuous scan with constant colour: line wraps and hsync of the full-size timing.
        for (int i = 0; i < 4000; i++) step(1'b1, 1'b1, 12'hFA5);
        // Every other clock enabled.
        for (int i = 0; i < 1200; i++) step(1'b1, (i % 2) == 0, 12'($urandom));
        // Mid-frame reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'($urandom));
        for (int i = 0; i < 1500; i++) step(1'b1, $urandom_range(0, 3) != 0, 12'($urandom));
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 12'($urandom));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'($urandom));
        @(posedge clk);
        #3;
        sb_stop = 1'b1;
        n_chk++;
        if (q0.size() + q1.size() + q2.size() == 0) n_pass++;
        else $display("FAIL drain got %0d left want 0", q0.size() + q1.size() + q2.size());
        n_chk++;
        if (fs_seen == fs_want && fs_want > 0) n_pass++;
        else $display("FAIL fs_count got %0d want %0d (nonzero)", fs_seen, fs_want);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
